// File: rtl/ctrl_pkg.sv
// Constants shared by the instruction deserializer and the request queue:
// instruction width, field offsets and deserializer state encoding.
package ctrl_pkg;
   localparam int ADDRW_DFLT   = 8;
   localparam int OPCODEW_DFLT = 2;
   localparam int INSTRW       = 2*ADDRW_DFLT + OPCODEW_DFLT;
   localparam int OPC_LSB      = 2*ADDRW_DFLT;
   localparam int KEY_LSB      = ADDRW_DFLT;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      LOCKOUT = 2'd2
   } state_e;
endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous pin plus a delay flop that
// yields single-cycle rise/fall strobes in the clk domain.
module sync_edge_det #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic sync,
   output logic rise,
   output logic fall
);
   logic meta_q, sync_q, dly_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         dly_q  <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~dly_q;
   assign fall = ~sync_q & dly_q;
endmodule

// File: rtl/instr_deserializer.sv
// Assembles oversampled 3-wire serial frames into opcode/key/text
// instructions and offers them to the request queue via valid/ready.
module instr_deserializer
   import ctrl_pkg::*;
#(
   parameter int ADDRW   = ADDRW_DFLT,
   parameter int OPCODEW = OPCODEW_DFLT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ser_cs_n,
   input  logic               ser_sclk,
   input  logic               ser_mosi,
   input  logic               ready_in,
   output logic               valid_out,
   output logic [OPCODEW-1:0] opcode,
   output logic [ADDRW-1:0]   key_addr,
   output logic [ADDRW-1:0]   text_addr,
   output logic               frame_err,
   output logic               drop_err
);
   localparam int IW     = 2*ADDRW + OPCODEW;
   localparam int OPC_LO = 2*ADDRW;
   localparam int KEY_LO = ADDRW;
   localparam int CW     = $clog2(IW+2);
   localparam logic [CW-1:0] CNT_FULL = CW'(IW);
   localparam logic [CW-1:0] CNT_SAT  = CW'(IW+1);

   logic cs_sync, cs_rise, cs_fall;
   logic sclk_sync, sclk_rise, sclk_fall;
   logic mosi_meta_q, mosi_sync_q;
   logic unused_sclk;

   sync_edge_det #(.RST_VAL(1'b1)) u_cs (
      .clk(clk), .rst_n(rst_n), .d(ser_cs_n),
      .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
   );
   sync_edge_det #(.RST_VAL(1'b0)) u_sclk (
      .clk(clk), .rst_n(rst_n), .d(ser_sclk),
      .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
   );
   assign unused_sclk = sclk_sync ^ sclk_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         mosi_meta_q <= ser_mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   state_e          state_q, state_d;
   logic [1:0]      warm_q, warm_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   sh_q, sh_d;
   logic [IW-1:0]   hold_q, hold_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            derr_q, derr_d;
   logic            commit, take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         warm_q  <= 2'd0;
         cnt_q   <= '0;
         sh_q    <= '0;
         hold_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         derr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         derr_q  <= derr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      derr_d  = 1'b0;
      commit  = 1'b0;
      take    = valid_q && ready_in;
      if (take) valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            // Synchroniser is still filling after reset; its first real
            // sample decides whether we woke up inside someone's frame.
            if (warm_q != 2'd3) begin
               if (warm_q == 2'd2 && !cs_sync) state_d = LOCKOUT;
            end else if (cs_fall) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d = IDLE;
               if (cnt_q == CNT_FULL) commit = 1'b1;
               else                   ferr_d = 1'b1;
            end else if (sclk_rise) begin
               if (cnt_q < CNT_FULL) sh_d = {sh_q[IW-2:0], mosi_sync_q};
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
            end
         end
         LOCKOUT: begin
            if (cs_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (commit) begin
         if (!valid_q || take) begin
            hold_d  = sh_q;
            valid_d = 1'b1;
         end else begin
            derr_d = 1'b1;
         end
      end
   end

   assign valid_out = valid_q;
   assign opcode    = hold_q[IW-1:OPC_LO];
   assign key_addr  = hold_q[OPC_LO-1:KEY_LO];
   assign text_addr = hold_q[KEY_LO-1:0];
   assign frame_err = ferr_q;
   assign drop_err  = derr_q;
endmodule

// File: tb/tb_instr_deserializer.sv
// Self-checking bench: table of single frames, hand-built corner sequences
// and randomized frames checked against a frame-level expectation model.
module tb_instr_deserializer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ser_cs_n = 1'b1;
   logic       ser_sclk = 1'b0;
   logic       ser_mosi = 1'b0;
   logic       ready_in = 1'b0;
   logic       valid_out;
   logic [1:0] opcode;
   logic [7:0] key_addr, text_addr;
   logic       frame_err, drop_err;

   always #5 clk = ~clk;

   instr_deserializer #(.ADDRW(8), .OPCODEW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ser_cs_n(ser_cs_n), .ser_sclk(ser_sclk), .ser_mosi(ser_mosi),
      .ready_in(ready_in), .valid_out(valid_out),
      .opcode(opcode), .key_addr(key_addr), .text_addr(text_addr),
      .frame_err(frame_err), .drop_err(drop_err)
   );

   int n_cmp = 0, n_fail = 0;
   int fe_cnt = 0, de_cnt = 0, vcyc = 0;
   logic [17:0] xlog[$];

   // Passive monitor: records every transfer and counts pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_out && ready_in) xlog.push_back({opcode, key_addr, text_addr});
         if (frame_err) fe_cnt++;
         if (drop_err)  de_cnt++;
         if (valid_out) vcyc++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic open_frame();
      ser_cs_n = 1'b0;
      tick(4);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n-1; i >= 0; i--) begin
         ser_mosi = v[i];
         tick(4);
         ser_sclk = 1'b1;
         tick(5);
         ser_sclk = 1'b0;
         tick(5);
      end
   endtask

   task automatic close_frame();
      ser_cs_n = 1'b1;
      tick(8);
   endtask

   task automatic send_frame(input logic [31:0] v, input int n);
      open_frame();
      send_bits(v, n);
      close_frame();
   endtask

   function automatic logic [17:0] pk(input logic [1:0] o, input logic [7:0] k, input logic [7:0] t);
      return {o, k, t};
   endfunction

   typedef struct {
      logic [31:0] bits;
      int          n;
      int          fe;
      int          xf;
      logic [17:0] pay;
   } vec_t;

   vec_t vt[8];
   int b_fe, b_de, b_x, b_v, bad;
   logic [17:0] old_p, new_p, exp_q[$];
   int exp_fe;

   initial begin
      vt[0] = '{32'(pk(2'b01, 8'hA5, 8'h3C)), 18, 0, 1, pk(2'b01, 8'hA5, 8'h3C)};
      vt[1] = '{32'h0001_2345, 17, 1, 0, 18'h0};
      vt[2] = '{32'h0005_5555, 19, 1, 0, 18'h0};
      vt[3] = '{32'(pk(2'b11, 8'h00, 8'hFF)), 18, 0, 1, pk(2'b11, 8'h00, 8'hFF)};
      vt[4] = '{32'h1, 1, 1, 0, 18'h0};
      vt[5] = '{32'h0, 0, 1, 0, 18'h0};
      vt[6] = '{32'h000F_0F0F, 20, 1, 0, 18'h0};
      vt[7] = '{32'(pk(2'b10, 8'h5A, 8'hC3)), 18, 0, 1, pk(2'b10, 8'h5A, 8'hC3)};

      // Reset state
      tick(3);
      chk("rst_valid", valid_out, 0);
      chk("rst_payload", {opcode, key_addr, text_addr}, 0);
      chk("rst_pulses", {frame_err, drop_err}, 0);
      rst_n = 1'b1;
      tick(6);
      chk("post_rst_valid", valid_out, 0);

      // Table-driven single frames with ready held high
      ready_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b_fe = fe_cnt; b_de = de_cnt; b_x = xlog.size(); b_v = vcyc;
         send_frame(vt[i].bits, vt[i].n);
         chk($sformatf("vec%0d_frame_err", i), fe_cnt - b_fe, vt[i].fe);
         chk($sformatf("vec%0d_drop_err", i), de_cnt - b_de, 0);
         chk($sformatf("vec%0d_xfers", i), xlog.size() - b_x, vt[i].xf);
         chk($sformatf("vec%0d_valid_cycles", i), vcyc - b_v, vt[i].xf);
         if (vt[i].xf == 1 && xlog.size() > b_x)
            chk($sformatf("vec%0d_payload", i), xlog[b_x], vt[i].pay);
      end

      // Backpressure: hold 20 cycles, then single transfer
      old_p = pk(2'b01, 8'hA5, 8'h3C);
      ready_in = 1'b0;
      b_x = xlog.size();
      send_frame(32'(old_p), 18);
      chk("bp_valid", valid_out, 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!valid_out || {opcode, key_addr, text_addr} !== old_p) bad++;
      end
      chk("bp_stable_cycles_bad", bad, 0);
      tick(1);
      ready_in = 1'b1;
      tick(1);
      ready_in = 1'b0;
      tick(2);
      chk("bp_xfers", xlog.size() - b_x, 1);
      if (xlog.size() > b_x) chk("bp_payload", xlog[b_x], old_p);
      chk("bp_valid_after", valid_out, 0);

      // Drop while held
      b_de = de_cnt; b_x = xlog.size();
      send_frame(32'(old_p), 18);
      send_frame(32'(pk(2'b00, 8'h01, 8'hFF)), 18);
      chk("drop_pulses", de_cnt - b_de, 1);
      chk("drop_held_payload", {opcode, key_addr, text_addr}, old_p);
      chk("drop_held_valid", valid_out, 1);
      ready_in = 1'b1;
      tick(3);
      chk("drop_xfers", xlog.size() - b_x, 1);
      if (xlog.size() > b_x) chk("drop_xfer_payload", xlog[b_x], old_p);

      // Commit in the same cycle as a handshake on the held entry
      ready_in = 1'b0;
      old_p = pk(2'b10, 8'h11, 8'h22);
      new_p = pk(2'b01, 8'h33, 8'h44);
      send_frame(32'(old_p), 18);
      b_de = de_cnt; b_x = xlog.size();
      open_frame();
      send_bits(32'(new_p), 18);
      ser_cs_n = 1'b1;
      tick(2);
      ready_in = 1'b1;
      tick(1);
      ready_in = 1'b0;
      @(negedge clk);
      chk("sim_valid", valid_out, 1);
      chk("sim_payload", {opcode, key_addr, text_addr}, new_p);
      tick(4);
      chk("sim_drop", de_cnt - b_de, 0);
      chk("sim_xfers", xlog.size() - b_x, 1);
      if (xlog.size() > b_x) chk("sim_old_payload", xlog[b_x], old_p);
      ready_in = 1'b1;
      tick(2);
      chk("sim_xfers2", xlog.size() - b_x, 2);
      if (xlog.size() > b_x + 1) chk("sim_new_payload", xlog[b_x+1], new_p);

      // Reset asserted mid-frame
      b_fe = fe_cnt; b_x = xlog.size(); b_v = vcyc;
      new_p = pk(2'b10, 8'h96, 8'h69);
      open_frame();
      send_bits(32'(new_p) >> 9, 9);
      rst_n = 1'b0;
      tick(3);
      chk("midrst_outputs", {valid_out, frame_err, drop_err}, 0);
      rst_n = 1'b1;
      tick(2);
      send_bits(32'(new_p), 9);
      close_frame();
      chk("midrst_frame_err", fe_cnt - b_fe, 0);
      chk("midrst_xfers", xlog.size() - b_x, 0);
      chk("midrst_valid_cycles", vcyc - b_v, 0);
      send_frame(32'(pk(2'b11, 8'hFF, 8'h00)), 18);
      chk("midrst_next_xfers", xlog.size() - b_x, 1);
      if (xlog.size() > b_x) chk("midrst_next_payload", xlog[b_x], pk(2'b11, 8'hFF, 8'h00));

      // Random back-to-back AES/SHA frames, then random-length frames
      exp_q = {};
      exp_fe = 0;
      b_fe = fe_cnt; b_x = xlog.size();
      for (int i = 0; i < 8; i++) begin
         logic [31:0] r;
         r = $urandom;
         new_p = {r[17], i[0], r[15:0]};
         exp_q.push_back(new_p);
         send_frame(32'(new_p), 18);
      end
      for (int i = 0; i < 6; i++) begin
         logic [31:0] r;
         int len;
         r = $urandom;
         len = $urandom_range(16, 20);
         if (len == 18) exp_q.push_back(r[17:0]);
         else           exp_fe++;
         send_frame(r, len);
      end
      chk("rnd_xfers", xlog.size() - b_x, exp_q.size());
      chk("rnd_frame_err", fe_cnt - b_fe, exp_fe);
      for (int i = 0; i < exp_q.size(); i++)
         if (b_x + i < xlog.size())
            chk($sformatf("rnd_payload%0d", i), xlog[b_x+i], exp_q[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
